// File: rtl/branch_predict_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_predict_unit_pkg
//   Shared definitions for the branch prediction unit.
//   - Pipeline width defines: `PC_WIDTH, `IMM_WIDTH, `DWIDTH, `OPCODE_WIDTH
//   - Branch opcodes: `BEQ, `BNE
//   - 2-bit counter encodings: `CNT_SNT, `CNT_WNT, `CNT_WT, `CNT_ST
//   - Package: typed copies of the counter encodings and a branch-target
//     helper function.
//   Optional feature macro used by the top: BPU_PERF_CNT_EN.
//   No ports (package file).
// ---------------------------------------------------------------------------
`ifndef BRANCH_PREDICT_UNIT_DEFS
`define BRANCH_PREDICT_UNIT_DEFS
`define PC_WIDTH     32
`define IMM_WIDTH    16
`define DWIDTH       32
`define OPCODE_WIDTH 6
`define BEQ          6'b000100
`define BNE          6'b000101
`define CNT_SNT      2'b00
`define CNT_WNT      2'b01
`define CNT_WT       2'b10
`define CNT_ST       2'b11
`endif

package branch_predict_unit_pkg;

    localparam logic [1:0] CNT_SNT = `CNT_SNT;
    localparam logic [1:0] CNT_WNT = `CNT_WNT;
    localparam logic [1:0] CNT_WT  = `CNT_WT;
    localparam logic [1:0] CNT_ST  = `CNT_ST;

    localparam logic [`PC_WIDTH-1:0] PC_STEP = 4;

    // pc + 4 + (sign-extended word offset << 2); wraps at `PC_WIDTH bits.
    function automatic logic [`PC_WIDTH-1:0] branch_target(
        input logic [`PC_WIDTH-1:0]  pc,
        input logic [`IMM_WIDTH-1:0] imm
    );
        logic [`PC_WIDTH-1:0] offset;
        offset = {{(`PC_WIDTH-`IMM_WIDTH){imm[`IMM_WIDTH-1]}}, imm} << 2;
        return pc + PC_STEP + offset;
    endfunction

endpackage

// File: rtl/bpu_sat_counter.sv
// ---------------------------------------------------------------------------
// bpu_sat_counter
//   Combinational 2-bit saturating counter update.
//   Ports:
//     i_cnt   - current counter value
//     i_taken - resolved branch outcome
//     o_cnt   - next counter value (increment on taken, decrement on
//               not taken, saturating at 11 / 00)
// ---------------------------------------------------------------------------
module bpu_sat_counter
    import branch_predict_unit_pkg::*;
(
    input  logic [1:0] i_cnt,
    input  logic       i_taken,
    output logic [1:0] o_cnt
);

    always_comb begin
        o_cnt = i_cnt;
        if (i_taken) begin
            if (i_cnt != CNT_ST) o_cnt = i_cnt + 2'd1;
        end else begin
            if (i_cnt != CNT_SNT) o_cnt = i_cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//   Direct-mapped BTB with 2-bit counters. IF-stage lookup is combinational
//   from the registered tables; ID-stage BEQ/BNE resolution updates the
//   tables and raises a registered one-cycle flush/redirect on mispredict.
//   Ports:
//     i_clk, i_rst              - clock, synchronous active-high reset
//     i_stall                   - freezes updates, suppresses flush
//     i_if_pc                   - fetch PC
//     o_pred_taken/o_pred_target- IF prediction
//     i_id_*                    - ID-stage branch info and forwarded data
//     o_flush/o_redirect_pc     - registered mispredict flush and target
//   Optional (macro BPU_PERF_CNT_EN): o_branch_cnt, o_mispred_cnt,
//     saturating 32-bit counts of resolves and mispredicts.
// ---------------------------------------------------------------------------
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int         DEPTH    = 16,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_stall,
    input  logic [`PC_WIDTH-1:0]     i_if_pc,
    output logic                     o_pred_taken,
    output logic [`PC_WIDTH-1:0]     o_pred_target,
    input  logic                     i_id_valid,
    input  logic                     i_id_branch,
    input  logic [`OPCODE_WIDTH-1:0] i_id_opcode,
    input  logic [`PC_WIDTH-1:0]     i_id_pc,
    input  logic [`IMM_WIDTH-1:0]    i_id_imm,
    input  logic [`DWIDTH-1:0]       i_id_data_r1,
    input  logic [`DWIDTH-1:0]       i_id_data_r2,
    input  logic                     i_id_pred_taken,
    input  logic [`PC_WIDTH-1:0]     i_id_pred_target,
    output logic                     o_flush,
    output logic [`PC_WIDTH-1:0]     o_redirect_pc
`ifdef BPU_PERF_CNT_EN
    ,
    output logic [31:0]              o_branch_cnt,
    output logic [31:0]              o_mispred_cnt
`endif
);

    localparam int INDEX_BITS = $clog2(DEPTH);
    localparam int TAG_BITS   = `PC_WIDTH - INDEX_BITS - 2;

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [TAG_BITS-1:0]  tag_q    [DEPTH];
    logic [TAG_BITS-1:0]  tag_d    [DEPTH];
    logic [`PC_WIDTH-1:0] target_q [DEPTH];
    logic [`PC_WIDTH-1:0] target_d [DEPTH];
    logic [1:0]           cnt_q    [DEPTH];
    logic [1:0]           cnt_d    [DEPTH];
    logic                 flush_q, flush_d;
    logic [`PC_WIDTH-1:0] redirect_q, redirect_d;

    // IF lookup
    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_BITS-1:0]   if_tag;
    logic                  if_hit;

    always_comb begin
        if_idx = i_if_pc[INDEX_BITS+1:2];
        if_tag = i_if_pc[`PC_WIDTH-1:INDEX_BITS+2];
        if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        // Gated by reset so the prediction is quiet while tables clear.
        o_pred_taken  = !i_rst && if_hit && cnt_q[if_idx][1];
        o_pred_target = o_pred_taken ? target_q[if_idx] : i_if_pc + PC_STEP;
    end

    // ID resolution
    logic [INDEX_BITS-1:0] id_idx;
    logic [TAG_BITS-1:0]   id_tag;
    logic                  id_hit;
    logic                  is_beq, is_bne;
    logic                  resolve;
    logic                  actual_taken;
    logic [`PC_WIDTH-1:0]  actual_target;
    logic                  mispredict;
    logic [1:0]            cnt_upd;

    bpu_sat_counter u_sat_counter (
        .i_cnt   (cnt_q[id_idx]),
        .i_taken (actual_taken),
        .o_cnt   (cnt_upd)
    );

    always_comb begin
        id_idx        = i_id_pc[INDEX_BITS+1:2];
        id_tag        = i_id_pc[`PC_WIDTH-1:INDEX_BITS+2];
        id_hit        = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
        is_beq        = (i_id_opcode == `BEQ);
        is_bne        = (i_id_opcode == `BNE);
        resolve       = i_id_valid && i_id_branch && (is_beq || is_bne) && !i_stall;
        actual_taken  = is_beq ? (i_id_data_r1 == i_id_data_r2)
                               : (i_id_data_r1 != i_id_data_r2);
        actual_target = branch_target(i_id_pc, i_id_imm);
        // A wrong target only matters when both sides say taken.
        mispredict    = (actual_taken != i_id_pred_taken) ||
                        (actual_taken && i_id_pred_taken &&
                         (i_id_pred_target != actual_target));

        valid_d    = valid_q;
        tag_d      = tag_q;
        target_d   = target_q;
        cnt_d      = cnt_q;
        flush_d    = 1'b0;
        redirect_d = redirect_q;

        if (resolve) begin
            if (actual_taken) begin
                valid_d[id_idx]  = 1'b1;
                tag_d[id_idx]    = id_tag;
                target_d[id_idx] = actual_target;
                cnt_d[id_idx]    = id_hit ? cnt_upd : CNT_WT;
            end else if (id_hit) begin
                cnt_d[id_idx] = cnt_upd;
            end
            if (mispredict) begin
                flush_d    = 1'b1;
                redirect_d = actual_taken ? actual_target : i_id_pc + PC_STEP;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q    <= '0;
            flush_q    <= 1'b0;
            redirect_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_INIT;
            end
        end else begin
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            target_q   <= target_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
        end
    end

    assign o_flush       = flush_q;
    assign o_redirect_pc = redirect_q;

`ifdef BPU_PERF_CNT_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resolve && (branch_cnt_q != 32'hFFFF_FFFF))
            branch_cnt_d = branch_cnt_q + 32'd1;
        if (resolve && mispredict && (mispred_cnt_q != 32'hFFFF_FFFF))
            mispred_cnt_d = mispred_cnt_q + 32'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign o_branch_cnt  = branch_cnt_q;
    assign o_mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_unit
//   Directed bench for branch_predict_unit (DEPTH=16, 32-bit PC/data,
//   16-bit imm, 6-bit opcode). Inputs change 1 time unit after the rising
//   edge; outputs are checked before the next edge.
// ---------------------------------------------------------------------------
module tb_branch_predict_unit;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_ADD = 6'b000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        id_valid;
    logic        id_branch;
    logic [5:0]  id_opcode;
    logic [31:0] id_pc;
    logic [15:0] id_imm;
    logic [31:0] id_r1;
    logic [31:0] id_r2;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;
    logic        flush;
    logic [31:0] redirect_pc;
`ifdef BPU_PERF_CNT_EN
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_stall          (stall),
        .i_if_pc          (if_pc),
        .o_pred_taken     (pred_taken),
        .o_pred_target    (pred_target),
        .i_id_valid       (id_valid),
        .i_id_branch      (id_branch),
        .i_id_opcode      (id_opcode),
        .i_id_pc          (id_pc),
        .i_id_imm         (id_imm),
        .i_id_data_r1     (id_r1),
        .i_id_data_r2     (id_r2),
        .i_id_pred_taken  (id_pred_taken),
        .i_id_pred_target (id_pred_target),
        .o_flush          (flush),
        .o_redirect_pc    (redirect_pc)
`ifdef BPU_PERF_CNT_EN
        ,
        .o_branch_cnt     (branch_cnt),
        .o_mispred_cnt    (mispred_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic exp_taken, input logic [31:0] exp_target);
        if_pc = pc;
        #1;
        check({tag, "_taken"},  {31'd0, pred_taken}, {31'd0, exp_taken});
        check({tag, "_target"}, pred_target, exp_target);
    endtask

    task automatic drive_branch(input logic [5:0] op, input logic [31:0] pc,
                                input logic [15:0] imm, input logic [31:0] r1,
                                input logic [31:0] r2, input logic pt,
                                input logic [31:0] ptgt);
        id_valid       = 1'b1;
        id_branch      = 1'b1;
        id_opcode      = op;
        id_pc          = pc;
        id_imm         = imm;
        id_r1          = r1;
        id_r2          = r2;
        id_pred_taken  = pt;
        id_pred_target = ptgt;
    endtask

    // Clock the driven branch, then check the registered flush/redirect
    // and that the flush drops again on the following cycle.
    task automatic resolve(input string tag, input logic exp_flush,
                           input logic [31:0] exp_redirect);
        tick;
        id_valid = 1'b0;
        check({tag, "_flush"}, {31'd0, flush}, {31'd0, exp_flush});
        if (exp_flush) check({tag, "_redirect"}, redirect_pc, exp_redirect);
        tick;
        check({tag, "_flush_drop"}, {31'd0, flush}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; if_pc = 32'h40;
        id_valid = 1'b0; id_branch = 1'b0; id_opcode = OP_ADD;
        id_pc = '0; id_imm = '0; id_r1 = '0; id_r2 = '0;
        id_pred_taken = 1'b0; id_pred_target = '0;
        tick;
        tick;
        rst = 1'b0;

        // Reset state
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_redirect", redirect_pc, 32'd0);
        lookup("rst_lookup", 32'h40, 1'b0, 32'h44);

        // BEQ 0x40 taken, predicted not taken -> allocate, counter 10
        drive_branch(OP_BEQ, 32'h40, 16'd3, 32'd10, 32'd10, 1'b0, 32'h44);
        lookup("same_cycle_old", 32'h40, 1'b0, 32'h44);
        resolve("beq_alloc", 1'b1, 32'h50);
        lookup("beq_alloc_lk", 32'h40, 1'b1, 32'h50);

        // Two more correct taken resolves -> counter 11
        drive_branch(OP_BEQ, 32'h40, 16'd3, 32'd10, 32'd10, 1'b1, 32'h50);
        resolve("beq_t2", 1'b0, 32'h0);
        drive_branch(OP_BEQ, 32'h40, 16'd3, 32'd10, 32'd10, 1'b1, 32'h50);
        resolve("beq_t3", 1'b0, 32'h0);

        // Not taken, predicted taken -> counter 10, still predicts taken
        drive_branch(OP_BEQ, 32'h40, 16'd3, 32'd5, 32'd10, 1'b1, 32'h50);
        resolve("beq_nt1", 1'b1, 32'h44);
        lookup("beq_nt1_lk", 32'h40, 1'b1, 32'h50);
        // Again -> counter 01, predicts not taken
        drive_branch(OP_BEQ, 32'h40, 16'd3, 32'd5, 32'd10, 1'b1, 32'h50);
        resolve("beq_nt2", 1'b1, 32'h44);
        lookup("beq_nt2_lk", 32'h40, 1'b0, 32'h44);

        // BNE 0x80 taken, correctly predicted -> no flush; evicts 0x40 (index 0)
        drive_branch(OP_BNE, 32'h80, 16'd10, 32'd11, 32'd10, 1'b1, 32'hAC);
        resolve("bne_alloc", 1'b0, 32'h0);
        lookup("bne_alloc_lk", 32'h80, 1'b1, 32'hAC);
        lookup("evicted_lk", 32'h40, 1'b0, 32'h44);
        lookup("alias_tag_lk", 32'h440, 1'b0, 32'h444);
        drive_branch(OP_BNE, 32'h80, 16'd10, 32'd11, 32'd10, 1'b1, 32'hAC);
        resolve("bne_inc", 1'b0, 32'h0);
        // Both taken but wrong predicted target
        drive_branch(OP_BNE, 32'h80, 16'd10, 32'd11, 32'd10, 1'b1, 32'hB0);
        resolve("bne_bad_tgt", 1'b1, 32'hAC);
        // Not taken from counter 11 -> 10, still taken
        drive_branch(OP_BNE, 32'h80, 16'd10, 32'd7, 32'd7, 1'b1, 32'hAC);
        resolve("bne_nt", 1'b1, 32'h84);
        lookup("bne_nt_lk", 32'h80, 1'b1, 32'hAC);

        // Stalled resolve: no flush, no table change
        drive_branch(OP_BEQ, 32'h40, 16'd3, 32'd1, 32'd1, 1'b0, 32'h44);
        stall = 1'b1;
        tick;
        stall = 1'b0;
        id_valid = 1'b0;
        check("stall_flush", {31'd0, flush}, 32'd0);
        lookup("stall_lk40", 32'h40, 1'b0, 32'h44);
        lookup("stall_lk80", 32'h80, 1'b1, 32'hAC);

        // Non-branch opcode and missing branch flag: ignored
        drive_branch(OP_ADD, 32'h40, 16'd3, 32'd1, 32'd1, 1'b0, 32'h44);
        resolve("non_branch_op", 1'b0, 32'h0);
        drive_branch(OP_BEQ, 32'h40, 16'd3, 32'd1, 32'd1, 1'b0, 32'h44);
        id_branch = 1'b0;
        resolve("no_branch_flag", 1'b0, 32'h0);
        lookup("ignored_lk", 32'h40, 1'b0, 32'h44);

        // Same-index IF lookup during ID update returns old entry
        drive_branch(OP_BEQ, 32'h40, 16'd3, 32'd1, 32'd1, 1'b0, 32'h44);
        lookup("collide_old", 32'h80, 1'b1, 32'hAC);
        resolve("collide", 1'b1, 32'h50);
        lookup("collide_new80", 32'h80, 1'b0, 32'h84);
        lookup("collide_new40", 32'h40, 1'b1, 32'h50);

        // Negative offset
        drive_branch(OP_BEQ, 32'h10, 16'hFFFE, 32'd3, 32'd3, 1'b0, 32'h14);
        resolve("neg_imm", 1'b1, 32'h0C);
        // PC wrap: not taken -> pc+4 wraps to 0; taken -> target wraps to 4
        drive_branch(OP_BEQ, 32'hFFFF_FFFC, 16'd1, 32'd1, 32'd2, 1'b1, 32'h4);
        resolve("wrap_nt", 1'b1, 32'h0);
        drive_branch(OP_BEQ, 32'hFFFF_FFFC, 16'd1, 32'd2, 32'd2, 1'b0, 32'h0);
        resolve("wrap_t", 1'b1, 32'h4);
        lookup("wrap_lk", 32'hFFFF_FFFC, 1'b1, 32'h4);

        // Mid-operation reset with a mispredicting resolve in flight
        drive_branch(OP_BEQ, 32'h10, 16'hFFFE, 32'd1, 32'd2, 1'b1, 32'h0C);
        rst = 1'b1;
        lookup("in_rst_lk", 32'h10, 1'b0, 32'h14);
        tick;
        rst = 1'b0;
        id_valid = 1'b0;
        check("mid_rst_flush", {31'd0, flush}, 32'd0);
        check("mid_rst_redirect", redirect_pc, 32'd0);
        lookup("mid_rst_lk10", 32'h10, 1'b0, 32'h14);
        lookup("mid_rst_lk40", 32'h40, 1'b0, 32'h44);
        lookup("mid_rst_lkwrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
        tick;
        check("post_rst_flush", {31'd0, flush}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the decode-stage branch compare/target logic.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, used for IF-stage prediction.
- ID-stage resolution of BEQ/BNE computes the actual outcome, updates the tables and raises a registered flush/redirect on mispredict.
- Sits between the PC-select mux (IF) and the ID register-read/compare path.

Parameters:
- DEPTH, 16, number of BTB/BHT entries; power of two, at least 2.
- INDEX_BITS, $clog2(DEPTH), index width; derived, not overridden.
- CNT_INIT, 2'b01, counter value at reset (weakly not-taken).

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous, active-high reset.
- i_stall  input  1  pipeline stall; freezes all updates and suppresses flush.
- i_if_pc  input  `PC_WIDTH  PC being fetched.
- o_pred_taken  output  1  prediction for i_if_pc.
- o_pred_target  output  `PC_WIDTH  predicted next PC (BTB target or i_if_pc+4).
- i_id_valid  input  1  ID stage holds a real instruction.
- i_id_branch  input  1  control unit branch flag.
- i_id_opcode  input  `OPCODE_WIDTH  ID opcode.
- i_id_pc  input  `PC_WIDTH  PC of the ID instruction.
- i_id_imm  input  `IMM_WIDTH  branch offset in words, signed.
- i_id_data_r1, i_id_data_r2  input  `DWIDTH  forwarded operands.
- i_id_pred_taken  input  1  prediction piped down from IF.
- i_id_pred_target  input  `PC_WIDTH  predicted target piped down from IF.
- o_flush  output  1  one-cycle flush of IF and IF/ID.
- o_redirect_pc  output  `PC_WIDTH  correct next PC, valid when o_flush=1.

Behaviour:
- Index = pc[INDEX_BITS+1:2]. Tag = pc[`PC_WIDTH-1:INDEX_BITS+2]. Storage per entry: valid, tag, target, 2-bit counter.
- IF lookup is combinational from registered tables, with zero latency.
  - Hit = valid && tag match.
  - o_pred_taken = hit && cnt[1].
  - o_pred_target = BTB target if o_pred_taken, else i_if_pc+4.
- Resolve condition: i_id_valid && i_id_branch && opcode is `BEQ or `BNE && !i_stall.
  - Any other case causes no table update and no flush.
- Actual outcome:
  - BEQ taken when r1==r2.
  - BNE taken when r1!=r2.
  - Target = i_id_pc + 4 + (sext(i_id_imm)<<2), truncated to `PC_WIDTH (wraps).
- Mispredict when either holds:
  - actual != i_id_pred_taken; or
  - both taken and i_id_pred_target != target.
- o_flush/o_redirect_pc are registered, with 1-cycle latency after the resolve cycle.
  - o_redirect_pc = target if taken, else i_id_pc+4.
  - o_flush is high for exactly one cycle per mispredict.
- Table update at the resolve clock edge:
  - Taken, hit: counter saturating increment (max 11), target rewritten.
  - Taken, miss: allocate; valid=1, tag, target, counter=2'b10.
  - Not taken, hit: counter saturating decrement (min 00).
  - Not taken, miss: no change.
- IF lookup and ID update to the same index in the same cycle: lookup returns the pre-update (old) contents.
- Reset (also mid-operation):
  - All valid bits cleared, counters set to CNT_INIT.
  - o_flush=0, o_redirect_pc=0, o_pred_taken=0.
  - An in-flight resolve in the reset cycle is discarded.

Optional Feature:
- Macro: BPU_PERF_CNT_EN.
- With the macro defined, two extra outputs are present:
  - o_branch_cnt [31:0]: increments on each resolve.
  - o_mispred_cnt [31:0]: increments on each mispredict.
  - Both saturate at 32'hFFFFFFFF, are cleared by i_rst and are frozen by i_stall.
- Without the macro, neither port nor counter exists; the core behaviour is unchanged.

Decomposition:
- Shared define header holds `PC_WIDTH, `IMM_WIDTH, `DWIDTH, `OPCODE_WIDTH, `BEQ and `BNE.
- Counter next-state encoding constants (SNT=00, WNT=01, WT=10, ST=11) are added to that header.
- One sub-module: bpu_sat_counter, the combinational 2-bit saturating update (cnt, taken -> next cnt), instantiated once on the update path.

Test Plan:
1. Reset, then i_if_pc=0x40 -> o_pred_taken=0, o_pred_target=0x44; o_flush=0.
2. BEQ at id_pc=0x40, imm=3, r1=r2=10, pred_taken=0 -> next cycle o_flush=1, o_redirect_pc=0x50. Then lookup 0x40 -> pred_taken=1, target=0x50.
3. Same BEQ resolved taken twice more (counter 11), then resolved with r1=5, r2=10 -> flush, redirect=0x44. Counter=10, still predicts taken.
4. BNE at id_pc=0x80, r1=11, r2=10, pred_taken=1, pred_target=0x80+4+(10<<2)=0xAC -> no flush. Counter increments.
5. Resolve BEQ with i_stall=1 -> no flush and tables unchanged. Simultaneous IF lookup/ID update at the same index -> returns old entry.
6. Negative imm=-2 at id_pc=0x10, taken -> redirect=0x0C. id_pc near 2^`PC_WIDTH-4 with not-taken -> redirect wraps to 0.
